// File: rtl/onn_pkg.sv
// Shared sizing and readout state encoding for the oscillator phase readout.
package onn_pkg;
  localparam int N_NEURON = 15;
  localparam int PHW      = 8;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_WAIT_WIN = 2'd1,
    RD_DUMP     = 2'd2,
    RD_DONE     = 2'd3
  } rd_state_e;
endpackage

// File: rtl/phase_capture.sv
// Per-neuron rising-edge detect and first-edge phase latch within one reference window.
module phase_capture #(
  parameter int PHW = onn_pkg::PHW
) (
  input  logic           sclk,
  input  logic           re_n,
  input  logic           osc,
  input  logic           ref_rise,
  input  logic [PHW-1:0] cnt,
  output logic [PHW-1:0] phase
);
  logic           osc_q, osc_d;
  logic           seen_q, seen_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic           osc_rise;

  assign osc_rise = osc & ~osc_q;

  // A new window presets the phase to all-ones so a silent neuron reads as saturated.
  always_comb begin
    osc_d   = osc;
    seen_d  = seen_q;
    phase_d = phase_q;
    if (ref_rise) begin
      seen_d  = osc_rise;
      phase_d = osc_rise ? '0 : '1;
    end else if (osc_rise && !seen_q) begin
      seen_d  = 1'b1;
      phase_d = cnt;
    end
  end

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      osc_q   <= 1'b0;
      seen_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      osc_q   <= osc_d;
      seen_q  <= seen_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
endmodule

// File: rtl/phase_readout.sv
// Phase measurement against a reference oscillator, binarisation, change detect and serial readout.
// state    | meaning
// IDLE     | no readout requested
// WAIT_WIN | readout requested, waiting for the next completed window
// DUMP     | streaming one neuron phase per cycle, cur_phase frozen
// DONE     | pattern valid until phi_to_no drops
module phase_readout #(
  parameter int N_NEURON = onn_pkg::N_NEURON,
  parameter int PHW      = onn_pkg::PHW
) (
  input  logic                sclk,
  input  logic                re_n,
  input  logic                ref_osc,
  input  logic [N_NEURON-1:0] osc,
  input  logic                drop,
  input  logic                state_cheak,
  input  logic                phi_to_no,
  output logic [N_NEURON-1:0] state_changed,
  output logic [N_NEURON-1:0] pattern,
  output logic                pattern_valid,
  output logic [PHW-1:0]      phase_out,
  output logic [3:0]          phase_idx,
  output logic                phase_vld,
  output logic                meas_err
);
  import onn_pkg::*;

  localparam logic [PHW-1:0] CNT_MAX  = '1;
  localparam logic [3:0]     IDX_LAST = 4'(N_NEURON - 1);

  logic                ref_q, ref_d, phi_q, phi_d;
  logic [PHW-1:0]      cnt_q, cnt_d, period_q, period_d;
  logic                meas_ok_q, meas_ok_d, meas_err_q, meas_err_d;
  logic [N_NEURON-1:0] snap_q, snap_d, pattern_q, pattern_d;
  logic [3:0]          idx_q, idx_d;
  logic                abort_q, abort_d;
  rd_state_e           state_q, state_d;
  logic [PHW-1:0]      cur_phase_q [N_NEURON];
  logic [PHW-1:0]      cur_phase_d [N_NEURON];
  logic [PHW-1:0]      phase [N_NEURON];
  logic [N_NEURON-1:0] bin, bin_new;
  logic                ref_rise, upd;

  assign ref_rise = ref_osc & ~ref_q;
  assign upd      = ref_rise && (cnt_q != CNT_MAX) && (state_q != RD_DUMP);

  for (genvar g = 0; g < N_NEURON; g++) begin : g_cap
    phase_capture #(.PHW(PHW)) u_cap (
      .sclk     (sclk),
      .re_n     (re_n),
      .osc      (osc[g]),
      .ref_rise (ref_rise),
      .cnt      (cnt_q),
      .phase    (phase[g])
    );
  end

  // bin_new is the pattern the current window would produce; used to latch pattern on update.
  always_comb begin
    bin     = '0;
    bin_new = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      bin[i]     = meas_ok_q && (cur_phase_q[i] >= (period_q >> 1));
      bin_new[i] = (phase[i] >= (cnt_q >> 1));
    end
  end

  always_comb begin
    ref_d       = ref_osc;
    phi_d       = phi_to_no;
    period_d    = period_q;
    meas_ok_d   = meas_ok_q;
    cur_phase_d = cur_phase_q;
    if (ref_rise)
      cnt_d = PHW'(1);
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
    if (upd) begin
      period_d    = cnt_q;
      cur_phase_d = phase;
      meas_ok_d   = 1'b1;
    end
    meas_err_d = !ref_rise && (cnt_d == CNT_MAX);
    snap_d     = (drop || state_cheak) ? bin : snap_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    abort_d   = abort_q;
    pattern_d = pattern_q;
    case (state_q)
      RD_IDLE: if (phi_to_no && !phi_q) state_d = RD_WAIT_WIN;
      RD_WAIT_WIN: begin
        if (!phi_to_no) begin
          state_d = RD_IDLE;
        end else if (upd) begin
          state_d   = RD_DUMP;
          idx_d     = '0;
          abort_d   = 1'b0;
          pattern_d = bin_new;
        end
      end
      RD_DUMP: begin
        if (!phi_to_no) abort_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = (abort_q || !phi_to_no) ? RD_IDLE : RD_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      RD_DONE: if (!phi_to_no) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      ref_q       <= 1'b0;
      phi_q       <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      meas_ok_q   <= 1'b0;
      meas_err_q  <= 1'b0;
      snap_q      <= '0;
      pattern_q   <= '0;
      idx_q       <= '0;
      abort_q     <= 1'b0;
      state_q     <= RD_IDLE;
      cur_phase_q <= '{default: '0};
    end else begin
      ref_q       <= ref_d;
      phi_q       <= phi_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      meas_ok_q   <= meas_ok_d;
      meas_err_q  <= meas_err_d;
      snap_q      <= snap_d;
      pattern_q   <= pattern_d;
      idx_q       <= idx_d;
      abort_q     <= abort_d;
      state_q     <= state_d;
      cur_phase_q <= cur_phase_d;
    end
  end

  assign state_changed = bin ^ snap_q;
  assign pattern       = pattern_q;
  assign pattern_valid = (state_q == RD_DONE);
  assign phase_vld     = (state_q == RD_DUMP);
  assign phase_idx     = idx_q;
  assign phase_out     = (state_q == RD_DUMP) ? cur_phase_q[idx_q] : '0;
  assign meas_err      = meas_err_q;
endmodule

// File: tb/tb_phase_readout.sv
// Directed bench for phase_readout: windows of 40 cycles with per-neuron osc edge offsets.
module tb_phase_readout;
  logic        sclk, re_n, ref_osc, drop, state_cheak, phi_to_no;
  logic [14:0] osc, state_changed, pattern;
  logic        pattern_valid, phase_vld, meas_err;
  logic [7:0]  phase_out;
  logic [3:0]  phase_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int osc_dly  [15];
  int osc_dly2 [15];
  int obs_idx [$];
  int obs_val [$];
  int obs_cyc [$];
  bit pv_seen;

  phase_readout #(.N_NEURON(15), .PHW(8)) dut (
    .sclk(sclk), .re_n(re_n), .ref_osc(ref_osc), .osc(osc), .drop(drop),
    .state_cheak(state_cheak), .phi_to_no(phi_to_no), .state_changed(state_changed),
    .pattern(pattern), .pattern_valid(pattern_valid), .phase_out(phase_out),
    .phase_idx(phase_idx), .phase_vld(phase_vld), .meas_err(meas_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int c);
    ref_osc = (c == 0);
    for (int i = 0; i < 15; i++) osc[i] = (c == osc_dly[i]) || (c == osc_dly2[i]);
  endtask

  task automatic window();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (phase_vld === 1'b1) begin
        obs_idx.push_back(int'(phase_idx));
        obs_val.push_back(int'(phase_out));
        obs_cyc.push_back(cyc);
      end
      if (pattern_valid === 1'b1) pv_seen = 1'b1;
      drive(c);
    end
  endtask

  task automatic clear_obs();
    obs_idx.delete(); obs_val.delete(); obs_cyc.delete(); pv_seen = 1'b0;
  endtask

  task automatic set_dly_zero();
    for (int i = 0; i < 15; i++) begin osc_dly[i] = 0; osc_dly2[i] = -1; end
  endtask

  task automatic test_reset();
    re_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      ref_osc = 1'($urandom_range(0, 1)); osc = 15'($urandom());
      drop = 1'($urandom_range(0, 1)); state_cheak = 1'($urandom_range(0, 1));
      phi_to_no = 1'($urandom_range(0, 1));
    end
    n_checks++; if (state_changed !== 15'h0) $display("FAIL reset_state_changed got %h exp 0000", state_changed); else n_pass++;
    n_checks++; if (pattern !== 15'h0) $display("FAIL reset_pattern got %h exp 0000", pattern); else n_pass++;
    n_checks++; if (pattern_valid !== 1'b0) $display("FAIL reset_pattern_valid got %b exp 0", pattern_valid); else n_pass++;
    n_checks++; if (phase_vld !== 1'b0) $display("FAIL reset_phase_vld got %b exp 0", phase_vld); else n_pass++;
    n_checks++; if (phase_out !== 8'h0) $display("FAIL reset_phase_out got %0d exp 0", phase_out); else n_pass++;
    n_checks++; if (phase_idx !== 4'h0) $display("FAIL reset_phase_idx got %0d exp 0", phase_idx); else n_pass++;
    n_checks++; if (meas_err !== 1'b0) $display("FAIL reset_meas_err got %b exp 0", meas_err); else n_pass++;
    ref_osc = 1'b0; osc = '0; drop = 1'b0; state_cheak = 1'b0; phi_to_no = 1'b0;
    tick();
    re_n = 1'b1;
    tick();
    n_checks++; if (phase_vld !== 1'b0) $display("FAIL release_phase_vld got %b exp 0", phase_vld); else n_pass++;
  endtask

  task automatic test_change_detect();
    set_dly_zero();
    drop = 1'b1;
    for (int w = 0; w < 3; w++) window();
    drop = 1'b0;
    osc_dly[3] = 20;
    window();
    osc_dly[3] = 0;
    n_checks++; if (state_changed !== 15'h0000) $display("FAIL chg_before got %h exp 0000", state_changed); else n_pass++;
    window();
    n_checks++; if (state_changed !== 15'h0008) $display("FAIL chg_after got %h exp 0008", state_changed); else n_pass++;
    tick();
    state_cheak = 1'b1;
    n_checks++; if (state_changed !== 15'h0008) $display("FAIL chg_during_cheak got %h exp 0008", state_changed); else n_pass++;
    tick();
    state_cheak = 1'b0;
    n_checks++; if (state_changed !== 15'h0000) $display("FAIL chg_after_cheak got %h exp 0000", state_changed); else n_pass++;
  endtask

  task automatic test_readout();
    osc_dly[3] = 20;
    window();
    phi_to_no = 1'b1;
    clear_obs();
    window();
    n_checks++; if (obs_idx.size() != 15) $display("FAIL rd_count got %0d exp 15", obs_idx.size()); else n_pass++;
    for (int i = 0; i < 15 && i < obs_idx.size(); i++) begin
      n_checks++;
      if (obs_idx[i] != i || obs_val[i] != ((i == 3) ? 20 : 0) || obs_cyc[i] != obs_cyc[0] + i)
        $display("FAIL rd_entry%0d got idx %0d val %0d cyc %0d exp idx %0d val %0d cyc %0d",
                 i, obs_idx[i], obs_val[i], obs_cyc[i], i, (i == 3) ? 20 : 0, obs_cyc[0] + i);
      else n_pass++;
    end
    n_checks++; if (pattern !== 15'h0008) $display("FAIL rd_pattern got %h exp 0008", pattern); else n_pass++;
    n_checks++; if (pattern_valid !== 1'b1) $display("FAIL rd_pv_set got %b exp 1", pattern_valid); else n_pass++;
    window();
    n_checks++; if (pattern_valid !== 1'b1) $display("FAIL rd_pv_held got %b exp 1", pattern_valid); else n_pass++;
    phi_to_no = 1'b0;
    tick();
    n_checks++; if (pattern_valid !== 1'b0) $display("FAIL rd_pv_clear got %b exp 0", pattern_valid); else n_pass++;
  endtask

  task automatic test_stall();
    for (int c = 0; c < 302; c++) begin
      tick();
      if (c == 5 || c == 250) begin
        n_checks++; if (meas_err !== 1'b0) $display("FAIL stall_early_err c%0d got %b exp 0", c, meas_err); else n_pass++;
      end
      if (c == 260 || c == 299) begin
        n_checks++; if (meas_err !== 1'b1) $display("FAIL stall_err c%0d got %b exp 1", c, meas_err); else n_pass++;
        n_checks++; if (state_changed !== 15'h0) $display("FAIL stall_chg c%0d got %h exp 0000", c, state_changed); else n_pass++;
      end
      if (c == 301) begin
        n_checks++; if (meas_err !== 1'b0) $display("FAIL stall_clear got %b exp 0", meas_err); else n_pass++;
        n_checks++; if (state_changed !== 15'h0) $display("FAIL stall_frozen got %h exp 0000", state_changed); else n_pass++;
      end
      ref_osc = (c == 0 || c == 300);
      osc = (c == 0 || c == 300) ? 15'h7fff : 15'h0;
    end
  endtask

  task automatic test_capture();
    int exp_v;
    set_dly_zero();
    window();
    osc_dly[0] = 10; osc_dly2[0] = 30; osc_dly[1] = -1; osc_dly[2] = 0; osc_dly[3] = 20;
    window();
    set_dly_zero();
    phi_to_no = 1'b1;
    clear_obs();
    window();
    n_checks++; if (obs_idx.size() != 15) $display("FAIL cap_count got %0d exp 15", obs_idx.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_idx.size(); i++) begin
      exp_v = (i == 0) ? 10 : (i == 1) ? 255 : (i == 3) ? 20 : 0;
      n_checks++;
      if (obs_idx[i] != i || obs_val[i] != exp_v)
        $display("FAIL cap_phase%0d got idx %0d val %0d exp idx %0d val %0d", i, obs_idx[i], obs_val[i], i, exp_v);
      else n_pass++;
    end
    n_checks++; if (pattern !== 15'h000a) $display("FAIL cap_pattern got %h exp 000a", pattern); else n_pass++;
    phi_to_no = 1'b0;
    tick();
  endtask

  task automatic test_abort_reset();
    bit found = 1'b0;
    set_dly_zero();
    phi_to_no = 1'b1;
    for (int k = 0; k < 120 && !found; k++) begin
      tick();
      if (phase_vld === 1'b1 && phase_idx === 4'd7) found = 1'b1;
      else drive(k % 40);
    end
    n_checks++; if (!found) $display("FAIL abort_reach_idx7 got none exp idx 7"); else n_pass++;
    re_n = 1'b0;
    #1;
    n_checks++; if (phase_vld !== 1'b0) $display("FAIL abort_vld got %b exp 0", phase_vld); else n_pass++;
    n_checks++; if (phase_idx !== 4'd0) $display("FAIL abort_idx got %0d exp 0", phase_idx); else n_pass++;
    n_checks++; if (pattern !== 15'h0) $display("FAIL abort_pattern got %h exp 0000", pattern); else n_pass++;
    phi_to_no = 1'b0; ref_osc = 1'b0; osc = '0;
    tick();
    tick();
    re_n = 1'b1;
    clear_obs();
    window();
    window();
    n_checks++; if (obs_idx.size() != 0) $display("FAIL abort_no_dump got %0d exp 0", obs_idx.size()); else n_pass++;
    n_checks++; if (pv_seen !== 1'b0) $display("FAIL abort_no_pv got %b exp 0", pv_seen); else n_pass++;
  endtask

  initial begin
    re_n = 1'b0; ref_osc = 1'b0; osc = '0; drop = 1'b0; state_cheak = 1'b0; phi_to_no = 1'b0;
    set_dly_zero();
    test_reset();
    test_change_detect();
    test_readout();
    test_stall();
    test_capture();
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
